// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO of any depth with watermarks, occupancy count and sticky errors.
// Data is valid one edge after the accepted read (zero in FWFT); a full FIFO rejects writes and flags overflow.
module sync_fifo_pro #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DATA_WIDTH < 1 || DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
      $error("sync_fifo_pro: illegal parameter combination");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  wr_acc;
  logic                  rd_acc;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flags derive only from the registered count, so they never depend on this cycle's requests.
  assign count        = cnt_q;
  assign full         = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= CNT_WIDTH'(AF_LEVEL));
  assign almost_empty = (cnt_q <= CNT_WIDTH'(AE_LEVEL));

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set.
      if (w_en && full)  overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  rvld_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_q <= '0;
          rvld_q <= 1'b0;
        end else begin
          rvld_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr];
        end
      end

      assign data_out = dout_q;
      assign rd_valid = rvld_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Drives three FIFO configurations (16 deep, 5 deep, 4 deep FWFT) with identical stimulus
// and compares each against a queue-based reference model every cycle.
module tb_sync_fifo_pro;

  localparam int NI = 3;
  localparam int DEP [NI] = '{16, 5, 4};
  localparam int AFL [NI] = '{14, 3, 3};
  localparam int AEL [NI] = '{2, 2, 1};
  localparam bit FWM [NI] = '{1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] dout_a [NI];
  logic       rv_a [NI];
  logic       full_a [NI];
  logic       empty_a [NI];
  logic       af_a [NI];
  logic       ae_a [NI];
  logic       ovf_a [NI];
  logic       udf_a [NI];
  logic [4:0] cnt16;
  logic [2:0] cnt5;
  logic [2:0] cnt4;
  int         cnt_a [NI];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mq [NI][$];
  logic [7:0] m_dout [NI];
  logic       m_rv [NI];
  logic       m_ovf [NI];
  logic       m_udf [NI];

  always #5 clk = ~clk;

  sync_fifo_pro #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
    .data_out(dout_a[0]), .rd_valid(rv_a[0]), .full(full_a[0]), .empty(empty_a[0]),
    .almost_full(af_a[0]), .almost_empty(ae_a[0]), .count(cnt16),
    .overflow(ovf_a[0]), .underflow(udf_a[0]));

  sync_fifo_pro #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(1'b0)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
    .data_out(dout_a[1]), .rd_valid(rv_a[1]), .full(full_a[1]), .empty(empty_a[1]),
    .almost_full(af_a[1]), .almost_empty(ae_a[1]), .count(cnt5),
    .overflow(ovf_a[1]), .underflow(udf_a[1]));

  sync_fifo_pro #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) u_dutf (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
    .data_out(dout_a[2]), .rd_valid(rv_a[2]), .full(full_a[2]), .empty(empty_a[2]),
    .almost_full(af_a[2]), .almost_empty(ae_a[2]), .count(cnt4),
    .overflow(ovf_a[2]), .underflow(udf_a[2]));

  always_comb begin
    cnt_a[0] = int'(cnt16);
    cnt_a[1] = int'(cnt5);
    cnt_a[2] = int'(cnt4);
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: a plain queue per configuration; decisions use occupancy before the edge.
  task automatic model_step(input logic w, input logic r, input logic [7:0] d,
                            input logic clr, input logic rst);
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        mq[i].delete();
        m_dout[i] = 8'h00;
        m_rv[i]   = 1'b0;
        m_ovf[i]  = 1'b0;
        m_udf[i]  = 1'b0;
      end else begin
        bit was_full, was_empty;
        was_full  = (mq[i].size() == DEP[i]);
        was_empty = (mq[i].size() == 0);
        m_rv[i] = 1'b0;
        if (r && !was_empty) begin
          m_dout[i] = mq[i].pop_front();
          m_rv[i]   = 1'b1;
        end
        if (w && !was_full) mq[i].push_back(d);
        m_ovf[i] = (w && was_full)  ? 1'b1 : (clr ? 1'b0 : m_ovf[i]);
        m_udf[i] = (r && was_empty) ? 1'b1 : (clr ? 1'b0 : m_udf[i]);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int n;
      n = mq[i].size();
      chk($sformatf("count[%0d]", i), cnt_a[i], n);
      chk($sformatf("empty[%0d]", i), int'(empty_a[i]), int'(n == 0));
      chk($sformatf("full[%0d]", i), int'(full_a[i]), int'(n == DEP[i]));
      chk($sformatf("almost_full[%0d]", i), int'(af_a[i]), int'(n >= AFL[i]));
      chk($sformatf("almost_empty[%0d]", i), int'(ae_a[i]), int'(n <= AEL[i]));
      chk($sformatf("overflow[%0d]", i), int'(ovf_a[i]), int'(m_ovf[i]));
      chk($sformatf("underflow[%0d]", i), int'(udf_a[i]), int'(m_udf[i]));
      if (FWM[i]) begin
        chk($sformatf("rd_valid[%0d]", i), int'(rv_a[i]), int'(n != 0));
        if (n != 0) chk($sformatf("data_out[%0d]", i), int'(dout_a[i]), int'(mq[i][0]));
      end else begin
        chk($sformatf("rd_valid[%0d]", i), int'(rv_a[i]), int'(m_rv[i]));
        chk($sformatf("data_out[%0d]", i), int'(dout_a[i]), int'(m_dout[i]));
      end
    end
  endtask

  task automatic cycle(input logic w, input logic r, input logic [7:0] d,
                       input logic clr, input logic rst);
    w_en = w; r_en = r; data_in = d; clr_err = clr; rst_n = rst;
    @(posedge clk);
    model_step(w, r, d, clr, rst);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_dout[i] = '0; m_rv[i] = 1'b0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
    end
    #2;
    // Reset values
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill 0x00..0x0F plus one rejected write, then drain plus one rejected read
    for (int k = 0; k < 17; k++) cycle(1'b1, 1'b0, 8'(k), 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Wrap across a non-power-of-two depth: 3 writes, 2 reads, 4 writes, 5 reads
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 8'h20 + 8'(k), 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 8'h30 + 8'(k), 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Single write visible in FWFT without r_en, then popped
    cycle(1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // Full plus simultaneous read/write, then clr_err
    for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, 8'h40 + 8'(k), 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read/write on an empty FIFO, then steady 20 cycles at count 8
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 8'h60 + 8'(k), 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);

    // Reset mid-stream with a write request present, then a fresh word
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 8'h80 + 8'(k), 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hC3, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with varying write/read bias
    for (int k = 0; k < 1500; k++) begin
      int bias;
      bias = (k / 250) % 3;
      cycle(($urandom_range(0, 9) < 3 + 2 * bias) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 7 - 2 * bias) ? 1'b1 : 1'b0,
            8'($urandom),
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_pro.md
# sync_fifo_pro

Single-clock, fully parametrised FIFO that supersedes the fixed power-of-two buffer for traffic that stays inside one clock domain. It adds arbitrary depth, a first-word-fall-through (FWFT) mode, an occupancy count, programmable almost-full/almost-empty watermarks, and sticky overflow/underflow error flags. It sits between a producer and consumer in the same clock domain and needs no pointer synchronizers.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 16, number of storage words; any integer ≥2, not required to be a power of two
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered-read mode, 1 = first-word-fall-through mode
- CNT_WIDTH, $clog2(DEPTH+1), derived, width of count
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  synchronous, active-low reset
- data_in  in  DATA_WIDTH  write data
- w_en  in  1  write request
- r_en  in  1  read request (pop in FWFT mode)
- clr_err  in  1  clears the sticky error flags
- data_out  out  DATA_WIDTH  read data
- rd_valid  out  1  standard mode: data_out updated this cycle; FWFT mode: equals !empty
- full, empty, almost_full, almost_empty  out  1 each  status flags
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Storage: DEPTH-entry register array, not reset. wr_ptr and rd_ptr each range 0..DEPTH-1 and wrap from DEPTH-1 to 0. Occupancy is held in count; there is no extra pointer bit.
- Write accepted = w_en && !full. Data is stored at wr_ptr, and wr_ptr advances.
- Read accepted = r_en && !empty. rd_ptr advances.
- The accept decisions use the registered full and empty values. There is no write-through when full and no read-through when empty, even if the opposite operation occurs in the same cycle.
- count: +1 on a write-only accept, −1 on a read-only accept, unchanged when both are accepted or neither is.
- Flags are pure functions of the registered count, with no combinational path from w_en/r_en:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count≥AF_LEVEL)
  - almost_empty = (count≤AE_LEVEL)
- Standard mode (FWFT=0): on an accepted read, data_out ← mem[rd_ptr] at the clock edge and rd_valid=1 for the following cycle. Otherwise data_out holds its value and rd_valid=0.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] continuously; it is meaningful whenever !empty. r_en pops the head. rd_valid = !empty.
- overflow is set by w_en && full; underflow is set by r_en && empty. The rejected operation has no other effect: no pointer, count, or memory change.
- Error flags stay set until clr_err=1 or reset. If clr_err and a new error occur in the same cycle, the flag stays set (set wins).

## Timing
- Reset (rst_n=0 at a rising edge) forces:
  - count=0, wr_ptr=0, rd_ptr=0
  - empty=1, full=0, almost_empty=1
  - almost_full=(AF_LEVEL==0 ? 1 : 0); parameter checks prevent AF_LEVEL==0
  - rd_valid=0, data_out=0 (standard mode), overflow=0, underflow=0
- Reset mid-operation discards all contents. Requests in the reset cycle are ignored and set no errors.
- Write-to-read latency: a write accepted at edge N gives empty=0 and count=1 after edge N.
  - FWFT: data_out equals the written word in cycle N+1.
  - Standard: the earliest accepted read is at edge N+1, with data_out/rd_valid valid after edge N+1.
- Full/empty are registered. The first rejected write occurs in the cycle after count reaches DEPTH.
- A simultaneous read and write when full: the read is accepted, the write is rejected, overflow is set, and count becomes DEPTH−1.
- A simultaneous read and write when empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- Wrap-around: with DEPTH=5, after 5 writes wr_ptr=0. Ordering is preserved across the wrap.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- **Reset values:** DEPTH=16, FWFT=0. After reset, check count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, data_out=0, overflow=0, underflow=0.
- **Fill and drain:** DEPTH=16. Write 0x00..0x0F.
  - almost_full rises when count=14; full rises after the 16th write.
  - A 17th write sets overflow and leaves count=16.
  - Reading 16 words returns 0x00..0x0F in order, each one cycle after its r_en.
  - A 17th read sets underflow; empty=1.
- **Non-power-of-two wrap:** DEPTH=5. Run 3 writes, 2 reads, then 4 writes (count=5, full). Reading 5 words returns the correct sequence across pointer wrap.
- **FWFT:** FWFT=1. A single write of 0xA5 makes data_out=0xA5 and rd_valid=1 in the next cycle with no r_en. One r_en then gives empty=1 and rd_valid=0.
- **Simultaneous operations:**
  - At count=16, w_en=r_en=1 gives count=15 and overflow=1.
  - At count=8, 20 cycles of simultaneous accepted read and write keep count=8 with data in order.
  - clr_err=1 clears overflow in the next cycle.
- **Reset mid-stream:** at count=7, assert rst_n=0 for one cycle with w_en=1. Afterwards check count=0, empty=1, overflow=0, and that the next write/read returns the new word.
